// File: rtl/systolic_array_vcounter.sv
// rtl/systolic_array_vcounter.sv - output-stationary systolic matrix multiplier sequenced by a frame counter
module systolic_array_vcounter #(
  parameter int SIZE   = 8,
  parameter int I_BITS = 8,
  parameter int O_BITS = 2*I_BITS+$clog2(SIZE)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [SIZE*I_BITS-1:0]        i_a_full,
  input  logic [SIZE*I_BITS-1:0]        i_b_full,
  output logic [SIZE*SIZE*O_BITS-1:0]   o_c_full
);

  // One frame is just long enough for the last skewed pair to reach the far corner PE.
  localparam int FRAME = 3*SIZE-2;
  localparam int CW    = $clog2(FRAME);
  localparam int PW    = 2*I_BITS;
  localparam logic [CW-1:0] LAST = CW'(FRAME-1);

  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        frame_end;
  logic [I_BITS-1:0]           a_q   [SIZE][SIZE];
  logic [I_BITS-1:0]           a_d   [SIZE][SIZE];
  logic [I_BITS-1:0]           b_q   [SIZE][SIZE];
  logic [I_BITS-1:0]           b_d   [SIZE][SIZE];
  logic [PW-1:0]               prod  [SIZE][SIZE];
  logic [O_BITS-1:0]           sum   [SIZE][SIZE];
  logic [O_BITS-1:0]           acc_q [SIZE][SIZE];
  logic [O_BITS-1:0]           acc_d [SIZE][SIZE];
  logic [SIZE*SIZE*O_BITS-1:0] c_q, c_d;

  // Frame counter: wraps to 0 after the last frame cycle.
  always_comb begin
    frame_end = (cnt_q == LAST);
    cnt_d     = frame_end ? '0 : cnt_q + 1'b1;
  end

  // Operand routing: edge PEs take the input lanes, inner PEs take their neighbour's registered operand.
  always_comb begin
    a_d = '{default: '0};
    b_d = '{default: '0};
    for (int r = 0; r < SIZE; r++) begin
      a_d[r][0] = i_a_full[r*I_BITS +: I_BITS];
      for (int c = 1; c < SIZE; c++) begin
        a_d[r][c] = a_q[r][c-1];
      end
    end
    for (int c = 0; c < SIZE; c++) begin
      b_d[0][c] = i_b_full[c*I_BITS +: I_BITS];
      for (int r = 1; r < SIZE; r++) begin
        b_d[r][c] = b_q[r-1][c];
      end
    end
  end

  // Multiply-accumulate; at frame end the final sum goes to the output and the accumulator restarts at 0.
  always_comb begin
    prod  = '{default: '0};
    sum   = '{default: '0};
    acc_d = '{default: '0};
    c_d   = c_q;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        prod[r][c]  = a_d[r][c] * b_d[r][c];
        sum[r][c]   = acc_q[r][c] + O_BITS'(prod[r][c]);
        acc_d[r][c] = frame_end ? '0 : sum[r][c];
        if (frame_end) begin
          c_d[(r*SIZE+c)*O_BITS +: O_BITS] = sum[r][c];
        end
      end
    end
  end

  // State registers; reset wins over a coincident frame-end capture.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      acc_q <= '{default: '0};
      c_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      c_q   <= c_d;
    end
  end

  assign o_c_full = c_q;

endmodule

// File: tb/tb_systolic_array_vcounter.sv
// tb/tb_systolic_array_vcounter.sv - scoreboard bench for the frame-sequenced systolic multiplier
module tb_systolic_array_vcounter;

  localparam int SIZE   = 8;
  localparam int I_BITS = 8;
  localparam int O_BITS = 19;
  localparam int F      = 3*SIZE-2;
  localparam int FLAT   = SIZE*SIZE*O_BITS;

  typedef logic [I_BITS-1:0] imat_t [SIZE][SIZE];
  typedef logic [O_BITS-1:0] omat_t [SIZE][SIZE];

  logic                   clk = 1'b0;
  logic                   rst;
  logic [SIZE*I_BITS-1:0] a_full;
  logic [SIZE*I_BITS-1:0] b_full;
  logic [FLAT-1:0]        c_full;

  int checks = 0;
  int errors = 0;

  logic [FLAT-1:0] exp_q [$];
  string           name_q [$];

  int   tb_cnt     = 0;
  logic have_frame = 1'b0;
  logic rst_hit    = 1'b0;
  logic prev_rst   = 1'b0;

  systolic_array_vcounter #(.SIZE(SIZE), .I_BITS(I_BITS), .O_BITS(O_BITS)) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_a_full (a_full),
    .i_b_full (b_full),
    .o_c_full (c_full)
  );

  always #5 clk = ~clk;

  // Bench-side frame position, used only to know when a result is due.
  always @(posedge clk) begin
    rst_hit  <= rst && !prev_rst;
    prev_rst <= rst;
    if (rst) begin
      tb_cnt     <= 0;
      have_frame <= 1'b0;
    end else if (tb_cnt == F-1) begin
      tb_cnt     <= 0;
      have_frame <= 1'b1;
    end else begin
      tb_cnt <= tb_cnt + 1;
    end
  end

  function automatic logic [FLAT-1:0] pack(input omat_t m);
    logic [FLAT-1:0] v;
    v = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        v[(r*SIZE+c)*O_BITS +: O_BITS] = m[r][c];
    return v;
  endfunction

  task automatic check_c(input string nm, input logic [FLAT-1:0] e);
    int br, bc;
    br = -1;
    bc = -1;
    checks++;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        if (br < 0 && c_full[(r*SIZE+c)*O_BITS +: O_BITS] !== e[(r*SIZE+c)*O_BITS +: O_BITS]) begin
          br = r;
          bc = c;
        end
    if (br >= 0) begin
      errors++;
      $display("FAIL %s C[%0d][%0d] got %0d expected %0d", nm, br, bc,
               c_full[(br*SIZE+bc)*O_BITS +: O_BITS], e[(br*SIZE+bc)*O_BITS +: O_BITS]);
    end
  endtask

  // Monitor: pops an expectation after each reset and each frame wrap; checks hold just before the wrap.
  initial begin
    logic [FLAT-1:0] last_exp;
    string           last_nm;
    logic            have_last;
    have_last = 1'b0;
    last_exp  = '0;
    last_nm   = "";
    forever begin
      @(negedge clk);
      if (rst_hit || (have_frame && tb_cnt == 0)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty output due at t=%0t with nothing expected", $time);
        end else begin
          last_exp  = exp_q.pop_front();
          last_nm   = name_q.pop_front();
          have_last = 1'b1;
          check_c(last_nm, last_exp);
        end
      end else if (have_last && !rst && tb_cnt == F-1) begin
        check_c({"hold_", last_nm}, last_exp);
      end
    end
  end

  task automatic push_exp(input string nm, input omat_t e);
    exp_q.push_back(pack(e));
    name_q.push_back(nm);
  endtask

  // Drives skewed lanes for n frame cycles starting at frame cycle 0.
  task automatic drive(input imat_t a, input imat_t b, input int n);
    logic [SIZE*I_BITS-1:0] la, lb;
    int k;
    for (int cyc = 0; cyc < n; cyc++) begin
      la = '0;
      lb = '0;
      for (int l = 0; l < SIZE; l++) begin
        k = cyc - l;
        if (k >= 0 && k < SIZE) begin
          la[l*I_BITS +: I_BITS] = a[l][k];
          lb[l*I_BITS +: I_BITS] = b[k][l];
        end
      end
      a_full = la;
      b_full = lb;
      @(posedge clk);
      #1;
    end
    a_full = '0;
    b_full = '0;
  endtask

  task automatic run_frame(input string nm, input imat_t a, input imat_t b, input omat_t e);
    push_exp(nm, e);
    drive(a, b, F);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    imat_t z, id, bk, ones, maxm, id2, threes;
    omat_t ez, eid, e8, emax, e6;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        z[r][c]      = 8'd0;
        id[r][c]     = (r == c) ? 8'd1 : 8'd0;
        id2[r][c]    = (r == c) ? 8'd2 : 8'd0;
        bk[r][c]     = 8'(r*8 + c);
        ones[r][c]   = 8'd1;
        maxm[r][c]   = 8'd255;
        threes[r][c] = 8'd3;
        ez[r][c]     = 19'd0;
        eid[r][c]    = 19'(r*8 + c);
        e8[r][c]     = 19'd8;
        emax[r][c]   = 19'd520200;
        e6[r][c]     = 19'd6;
      end
    end

    rst    = 1'b1;
    a_full = '0;
    b_full = '0;
    push_exp("reset", ez);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame("idle0", z, z, ez);
    run_frame("idle1", z, z, ez);
    run_frame("identity", id, bk, eid);
    run_frame("ones", ones, ones, e8);
    run_frame("max", maxm, maxm, emax);
    run_frame("b2b_ones", ones, ones, e8);
    run_frame("b2b_2i_x3", id2, threes, e6);

    push_exp("mid_reset", ez);
    drive(ones, ones, 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame("after_reset", id, bk, eid);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
